// File: rtl/bp_redirect_ctrl_if.sv
// Signal bundle between bp_redirect_ctrl (master) and its fetch / EX / BTB-update neighbours (slave).
// Defining BP_STATS_EN adds the stat_br / stat_miss / stat_drop counter outputs.
interface bp_redirect_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] if_pc;
    logic              btb_hit;
    logic [ADDR_W-1:0] btb_pred_pc;
    logic [ADDR_W-1:0] next_pc;
    logic              stall_ifid;
    logic              stall_idex;
    logic              flush_ifid;
    logic              flush_idex;
    logic              ex_is_br;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              bp_flush;
    logic              upd_valid;
    logic              upd_ready;
    logic              upd_op;
    logic [ADDR_W-1:0] upd_pc;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_drop;
`ifdef BP_STATS_EN
    logic [31:0]       stat_br;
    logic [31:0]       stat_miss;
    logic [31:0]       stat_drop;
`endif

    modport master (
        input  if_pc, btb_hit, btb_pred_pc, stall_ifid, stall_idex, flush_ifid, flush_idex,
               ex_is_br, ex_taken, ex_target, upd_ready,
        output next_pc, redirect, redirect_pc, bp_flush, upd_valid, upd_op, upd_pc,
               upd_target, upd_drop
`ifdef BP_STATS_EN
        , output stat_br, stat_miss, stat_drop
`endif
    );

    modport slave (
        output if_pc, btb_hit, btb_pred_pc, stall_ifid, stall_idex, flush_ifid, flush_idex,
               ex_is_br, ex_taken, ex_target, upd_ready,
        input  next_pc, redirect, redirect_pc, bp_flush, upd_valid, upd_op, upd_pc,
               upd_target, upd_drop
`ifdef BP_STATS_EN
        , input stat_br, stat_miss, stat_drop
`endif
    );
endinterface

// File: rtl/bp_redirect_ctrl.sv
// Branch-prediction controller: next-PC select, IF->ID->EX prediction shadows, EX mispredict
// redirect and a small BTB-update FIFO. Optional statistics counters under macro BP_STATS_EN.
module bp_redirect_ctrl #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned UQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    bp_redirect_ctrl_if.master bus
);
    localparam int unsigned PTR_W = (UQ_DEPTH > 1) ? $clog2(UQ_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(UQ_DEPTH);

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] pc;
        logic              hit;
        logic [ADDR_W-1:0] pred;
    } stage_t;

    typedef struct packed {
        logic              op;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] target;
    } upd_t;

    stage_t            id_q, id_d, ex_q, ex_d;
    logic              resolved_q, resolved_d;
    upd_t              mem_q [UQ_DEPTH];
    upd_t              mem_d [UQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              resolve, mispredict, redirect;
    logic [ADDR_W-1:0] seq_pc, fix_pc;
    upd_t              req, head;
    logic              empty, full, deq, enq, drop;
    logic              flush_id, flush_ex;

    // EX resolution: compare the carried prediction with the actual outcome
    always_comb begin
        seq_pc     = ex_q.pc + PC_STEP;
        resolve    = ex_q.v & ~resolved_q;
        mispredict = 1'b0;
        fix_pc     = seq_pc;
        req        = '0;
        req.pc     = ex_q.pc;
        if (bus.ex_is_br && bus.ex_taken) begin
            if (!ex_q.hit || (ex_q.pred != bus.ex_target)) begin
                mispredict = 1'b1;
                fix_pc     = bus.ex_target;
                req.target = bus.ex_target;
            end
        end else if (ex_q.hit) begin
            // not-taken branch or non-branch alias hit: BTB entry is stale
            mispredict = 1'b1;
            req.op     = 1'b1;
        end
        redirect = resolve & mispredict;
    end

    assign bus.redirect    = redirect;
    assign bus.redirect_pc = fix_pc;
    assign bus.bp_flush    = redirect;
    assign bus.next_pc     = redirect    ? fix_pc :
                             bus.btb_hit ? bus.btb_pred_pc : (bus.if_pc + PC_STEP);

    // Shadow pipeline: flush beats stall beats advance
    always_comb begin
        flush_id   = bus.flush_ifid | redirect;
        flush_ex   = bus.flush_idex | redirect;
        id_d       = id_q;
        ex_d       = ex_q;
        if (flush_id) begin
            id_d.v = 1'b0;
        end else if (!bus.stall_ifid) begin
            id_d.v    = 1'b1;
            id_d.pc   = bus.if_pc;
            id_d.hit  = bus.btb_hit;
            id_d.pred = bus.btb_pred_pc;
        end
        if (flush_ex) begin
            ex_d.v = 1'b0;
        end else if (!bus.stall_idex) begin
            ex_d = id_q;
        end
        // remember a decision made while EX is held so it is not repeated
        resolved_d = (flush_ex || !bus.stall_idex) ? 1'b0 : (resolved_q | resolve);
    end

    // Update FIFO; a full FIFO still accepts when the head leaves in the same cycle
    always_comb begin
        empty    = (cnt_q == '0);
        full     = (cnt_q == CNT_FULL);
        deq      = ~empty & bus.upd_ready;
        enq      = redirect & (~full | deq);
        drop     = redirect & full & ~deq;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq) begin
            mem_d[wr_ptr_q] = req;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(enq) - CNT_W'(deq);
    end

    assign head           = mem_q[rd_ptr_q];
    assign bus.upd_valid  = ~empty;
    assign bus.upd_op     = head.op;
    assign bus.upd_pc     = head.pc;
    assign bus.upd_target = head.target;
    assign bus.upd_drop   = drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q       <= '0;
            ex_q       <= '0;
            resolved_q <= 1'b0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            id_q       <= id_d;
            ex_q       <= ex_d;
            resolved_q <= resolved_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_br_q, stat_br_d, stat_miss_q, stat_miss_d, stat_drop_q, stat_drop_d;

    // saturating event counters
    always_comb begin
        stat_br_d   = stat_br_q;
        stat_miss_d = stat_miss_q;
        stat_drop_d = stat_drop_q;
        if (resolve && bus.ex_is_br && (stat_br_q != '1)) stat_br_d   = stat_br_q + 32'd1;
        if (redirect && (stat_miss_q != '1))              stat_miss_d = stat_miss_q + 32'd1;
        if (drop && (stat_drop_q != '1))                  stat_drop_d = stat_drop_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_q   <= '0;
            stat_miss_q <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_br_q   <= stat_br_d;
            stat_miss_q <= stat_miss_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign bus.stat_br   = stat_br_q;
    assign bus.stat_miss = stat_miss_q;
    assign bus.stat_drop = stat_drop_q;
`endif
endmodule

// File: tb/tb_bp_redirect_ctrl.sv
// Directed bench for bp_redirect_ctrl: a behavioural model (instruction slots + update queue)
// is checked every cycle, plus hand-computed literal expectations at key points.
module tb_bp_redirect_ctrl;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 2;

    typedef logic [AW-1:0] addr_t;
    typedef struct { logic v; addr_t pc; logic hit; addr_t pred; } slot_t;
    typedef struct { logic op; addr_t pc; addr_t target; } upd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bp_redirect_ctrl_if #(.ADDR_W(AW)) bus ();
    bp_redirect_ctrl #(.ADDR_W(AW), .UQ_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int    n_cmp = 0;
    int    n_bad = 0;
    slot_t m_id, m_ex;
    logic  m_done;
    upd_t  m_q[$];
    addr_t fpc = 32'h1000;

    task automatic chk(input string name, input addr_t act, input addr_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // What the instruction in EX must do this cycle, from the resolution rules
    function automatic void predict(output logic r, output addr_t rpc, output upd_t u);
        logic insert, inval;
        r = 1'b0;
        rpc = '0;
        u = '{op: 1'b0, pc: m_ex.pc, target: '0};
        if (!m_ex.v || m_done) return;
        insert = bus.ex_is_br && bus.ex_taken && !(m_ex.hit && m_ex.pred == bus.ex_target);
        inval  = (bus.ex_is_br && !bus.ex_taken && m_ex.hit) || (!bus.ex_is_br && m_ex.hit);
        if (insert) begin
            r = 1'b1; rpc = bus.ex_target; u.target = bus.ex_target;
        end else if (inval) begin
            r = 1'b1; rpc = m_ex.pc + 32'd4; u.op = 1'b1;
        end
    endfunction

    task automatic compare();
        logic  r;
        addr_t rpc, nxt;
        upd_t  u;
        predict(r, rpc, u);
        nxt = r ? rpc : (bus.btb_hit ? bus.btb_pred_pc : bus.if_pc + 32'd4);
        chk("next_pc", bus.next_pc, nxt);
        chk("redirect", AW'(bus.redirect), AW'(r));
        chk("bp_flush", AW'(bus.bp_flush), AW'(r));
        if (r) chk("redirect_pc", bus.redirect_pc, rpc);
        chk("upd_drop", AW'(bus.upd_drop), AW'(r && m_q.size() == DEPTH && !bus.upd_ready));
        chk("upd_valid", AW'(bus.upd_valid), AW'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("upd_op", AW'(bus.upd_op), AW'(m_q[0].op));
            chk("upd_pc", bus.upd_pc, m_q[0].pc);
            if (!m_q[0].op) chk("upd_target", bus.upd_target, m_q[0].target);
        end
    endtask

    task automatic model_clear();
        m_id = '{v: 1'b0, pc: '0, hit: 1'b0, pred: '0};
        m_ex = m_id;
        m_done = 1'b0;
        m_q.delete();
    endtask

    task automatic model_update();
        logic  r, was_full, leave;
        addr_t rpc;
        upd_t  u, gone;
        slot_t nid, nex;
        predict(r, rpc, u);
        was_full = (m_q.size() == DEPTH);
        leave    = (m_q.size() != 0) && bus.upd_ready;
        if (leave) gone = m_q.pop_front();
        if (r && (!was_full || leave)) m_q.push_back(u);
        nid = m_id;
        nex = m_ex;
        if (bus.flush_ifid || r) nid.v = 1'b0;
        else if (!bus.stall_ifid) nid = '{v: 1'b1, pc: bus.if_pc, hit: bus.btb_hit, pred: bus.btb_pred_pc};
        if (bus.flush_idex || r) nex.v = 1'b0;
        else if (!bus.stall_idex) nex = m_id;
        // an instruction held in EX keeps its one decision until it moves or dies
        if (bus.flush_idex || r || !bus.stall_idex) m_done = 1'b0;
        else if (m_ex.v) m_done = 1'b1;
        m_id = nid;
        m_ex = nex;
    endtask

    task automatic half_a();
        @(negedge clk);
        compare();
    endtask

    task automatic half_b();
        @(posedge clk);
        if (rst) model_clear();
        else model_update();
        #1;
    endtask

    task automatic step();
        half_a();
        half_b();
    endtask

    task automatic set_if(input addr_t pc, input logic hit, input addr_t pred);
        bus.if_pc = pc; bus.btb_hit = hit; bus.btb_pred_pc = pred;
    endtask

    task automatic filler();
        set_if(fpc, 1'b0, '0);
        fpc = fpc + 32'd4;
    endtask

    task automatic set_ex(input logic br, input logic tk, input addr_t tgt);
        bus.ex_is_br = br; bus.ex_taken = tk; bus.ex_target = tgt;
    endtask

    // bring an instruction from IF to EX; on return it sits in EX for the coming cycle
    task automatic to_ex(input addr_t pc, input logic hit, input addr_t pred);
        set_if(pc, hit, pred);
        step();
        filler();
        step();
        filler();
    endtask

    // full mispredict (taken, no hit) taking one EX cycle
    task automatic miss(input addr_t pc, input addr_t tgt);
        to_ex(pc, 1'b0, '0);
        set_ex(1'b1, 1'b1, tgt);
        step();
        set_ex(1'b0, 1'b0, '0);
    endtask

    initial begin
        rst = 1'b1;
        model_clear();
        bus.stall_ifid = 1'b0; bus.stall_idex = 1'b0;
        bus.flush_ifid = 1'b0; bus.flush_idex = 1'b0;
        bus.upd_ready = 1'b0;
        set_ex(1'b0, 1'b0, '0);
        set_if(32'h100, 1'b0, '0);

        // reset state
        half_a();
        chk("rst next_pc", bus.next_pc, 32'h104);
        chk("rst upd_valid", AW'(bus.upd_valid), '0);
        chk("rst redirect", AW'(bus.redirect), '0);
        chk("rst upd_pc", bus.upd_pc, '0);
        chk("rst upd_target", bus.upd_target, '0);
        chk("rst upd_op", AW'(bus.upd_op), '0);
        half_b();
        set_if(32'h100, 1'b1, 32'h180);
        half_a();
        chk("hit next_pc", bus.next_pc, 32'h180);
        half_b();
        rst = 1'b0;
        set_if(32'hFFFF_FFFC, 1'b0, '0);
        half_a();
        chk("wrap next_pc", bus.next_pc, 32'h0);
        half_b();

        // taken, no hit: insert held until accepted
        to_ex(32'h200, 1'b0, '0);
        set_ex(1'b1, 1'b1, 32'h240);
        half_a();
        chk("miss redirect", AW'(bus.redirect), 32'd1);
        chk("miss redirect_pc", bus.redirect_pc, 32'h240);
        chk("miss bp_flush", AW'(bus.bp_flush), 32'd1);
        half_b();
        set_ex(1'b0, 1'b0, '0);
        filler();
        half_a();
        chk("ins redirect gone", AW'(bus.redirect), '0);
        chk("ins upd_valid", AW'(bus.upd_valid), 32'd1);
        chk("ins upd_op", AW'(bus.upd_op), '0);
        chk("ins upd_pc", bus.upd_pc, 32'h200);
        chk("ins upd_target", bus.upd_target, 32'h240);
        half_b();
        step(); step();
        bus.upd_ready = 1'b1;
        step();
        bus.upd_ready = 1'b0;
        half_a();
        chk("drained upd_valid", AW'(bus.upd_valid), '0);
        half_b();

        // hit but not taken -> invalidate; hit and correct -> nothing
        bus.upd_ready = 1'b1;
        to_ex(32'h200, 1'b1, 32'h240);
        set_ex(1'b1, 1'b0, 32'h240);
        half_a();
        chk("nt redirect_pc", bus.redirect_pc, 32'h204);
        half_b();
        set_ex(1'b0, 1'b0, '0);
        filler();
        half_a();
        chk("inv upd_op", AW'(bus.upd_op), 32'd1);
        chk("inv upd_pc", bus.upd_pc, 32'h200);
        half_b();
        to_ex(32'h200, 1'b1, 32'h240);
        set_ex(1'b1, 1'b1, 32'h240);
        half_a();
        chk("correct redirect", AW'(bus.redirect), '0);
        half_b();
        set_ex(1'b0, 1'b0, '0);
        filler();
        half_a();
        chk("correct no enqueue", AW'(bus.upd_valid), '0);
        half_b();
        to_ex(32'h208, 1'b1, 32'h300);
        half_a();
        chk("alias redirect_pc", bus.redirect_pc, 32'h20C);
        half_b();
        filler();
        step();
        to_ex(32'h210, 1'b0, '0);
        set_ex(1'b1, 1'b0, 32'h280);
        step();
        set_ex(1'b0, 1'b0, '0);
        filler();
        step();

        // mispredict held by stall_idex: one redirect, one entry
        bus.upd_ready = 1'b0;
        to_ex(32'h400, 1'b0, '0);
        set_ex(1'b1, 1'b1, 32'h480);
        bus.stall_idex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            half_a();
            chk("stall redirect", AW'(bus.redirect), AW'(i == 0));
            half_b();
        end
        bus.stall_idex = 1'b0;
        set_ex(1'b0, 1'b0, '0);
        filler();
        step();
        bus.upd_ready = 1'b1;
        half_a();
        chk("stall entry pc", bus.upd_pc, 32'h400);
        half_b();
        half_a();
        chk("stall single entry", AW'(bus.upd_valid), '0);
        half_b();

        // correct under stall, then outcome changes: already decided
        to_ex(32'h440, 1'b1, 32'h4C0);
        set_ex(1'b1, 1'b1, 32'h4C0);
        bus.stall_idex = 1'b1;
        step();
        set_ex(1'b1, 1'b0, 32'h4C0);
        half_a();
        chk("resolved no redirect", AW'(bus.redirect), '0);
        half_b();
        bus.stall_idex = 1'b0;
        set_ex(1'b0, 1'b0, '0);
        step();

        // three mispredicts into a stalled FIFO
        bus.upd_ready = 1'b0;
        miss(32'h300, 32'h3A0);
        miss(32'h310, 32'h3B0);
        to_ex(32'h320, 1'b0, '0);
        set_ex(1'b1, 1'b1, 32'h3C0);
        half_a();
        chk("full upd_drop", AW'(bus.upd_drop), 32'd1);
        chk("full redirect", AW'(bus.redirect), 32'd1);
        half_b();
        set_ex(1'b0, 1'b0, '0);
        bus.upd_ready = 1'b1;
        filler();
        half_a();
        chk("drain0 pc", bus.upd_pc, 32'h300);
        half_b();
        half_a();
        chk("drain1 pc", bus.upd_pc, 32'h310);
        chk("drain1 target", bus.upd_target, 32'h3B0);
        half_b();
        half_a();
        chk("drain empty", AW'(bus.upd_valid), '0);
        half_b();

        // full FIFO with simultaneous dequeue and enqueue
        bus.upd_ready = 1'b0;
        miss(32'h500, 32'h5A0);
        miss(32'h510, 32'h5B0);
        to_ex(32'h520, 1'b0, '0);
        set_ex(1'b1, 1'b1, 32'h5C0);
        bus.upd_ready = 1'b1;
        half_a();
        chk("fulldeq upd_drop", AW'(bus.upd_drop), '0);
        half_b();
        set_ex(1'b0, 1'b0, '0);
        bus.upd_ready = 1'b0;
        half_a();
        chk("fulldeq head", bus.upd_pc, 32'h510);
        half_b();
        bus.upd_ready = 1'b1;
        step(); step(); step();

        // external flushes kill the instruction before EX
        set_if(32'h600, 1'b1, 32'h700);
        bus.flush_ifid = 1'b1;
        step();
        bus.flush_ifid = 1'b0;
        filler(); step();
        filler();
        half_a();
        chk("flush_ifid no redirect", AW'(bus.redirect), '0);
        half_b();
        set_if(32'h620, 1'b1, 32'h700);
        step();
        bus.flush_idex = 1'b1;
        filler(); step();
        bus.flush_idex = 1'b0;
        filler();
        half_a();
        chk("flush_idex no redirect", AW'(bus.redirect), '0);
        half_b();

        // reset with a full FIFO and a mispredict sitting in EX
        bus.upd_ready = 1'b0;
        miss(32'h700, 32'h7A0);
        miss(32'h710, 32'h7B0);
        to_ex(32'h720, 1'b0, '0);
        set_ex(1'b1, 1'b1, 32'h7C0);
        rst = 1'b1;
        model_clear();
        half_a();
        chk("midrst upd_valid", AW'(bus.upd_valid), '0);
        chk("midrst redirect", AW'(bus.redirect), '0);
        chk("midrst bp_flush", AW'(bus.bp_flush), '0);
        half_b();
        rst = 1'b0;
        set_ex(1'b0, 1'b0, '0);
        bus.upd_ready = 1'b1;
        filler(); step();
        filler(); step();
        half_a();
        chk("postrst upd_valid", AW'(bus.upd_valid), '0);
        half_b();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bp_redirect_ctrl.md
Name: bp_redirect_ctrl

Overview:
- Branch-prediction controller between the IF-stage BTB lookup, the pipeline registers and the EX-stage branch resolution.
- Selects next fetch PC from the BTB result and carries prediction info down IF→ID→EX in shadow registers.
- In EX, compares the prediction against the actual outcome; on mismatch, raises redirect/flush and queues a BTB insert or invalidate.
- Sends queued updates to the BTB write port through a valid/ready FIFO.

Parameters:
ADDR_W, 32, PC/target width
UQ_DEPTH, 2, update FIFO depth (power of 2, ≥2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
if_pc  in  ADDR_W  current fetch PC
btb_hit  in  1  BTB lookup hit for if_pc
btb_pred_pc  in  ADDR_W  BTB predicted target
next_pc  out  ADDR_W  fetch PC for next cycle
stall_ifid  in  1  hold IF/ID (from hazard unit)
stall_idex  in  1  hold ID/EX
flush_ifid  in  1  external IF/ID flush
flush_idex  in  1  external ID/EX flush
ex_is_br  in  1  EX instruction is branch/jump
ex_taken  in  1  actual direction
ex_target  in  ADDR_W  actual taken target
redirect  out  1  mispredict, fetch from redirect_pc
redirect_pc  out  ADDR_W  corrected PC
bp_flush  out  1  flush IF/ID and ID/EX (equals redirect)
upd_valid  out  1  BTB update request
upd_ready  in  1  BTB accepts update
upd_op  out  1  0=insert, 1=invalidate
upd_pc  out  ADDR_W  branch PC
upd_target  out  ADDR_W  target for insert
upd_drop  out  1  one-cycle pulse: update lost, FIFO full

Behaviour:
- Reset: all shadow valid bits 0, FIFO empty, resolved flag 0. Outputs: redirect=0, bp_flush=0, upd_valid=0, upd_drop=0, upd_op/pc/target=0. next_pc follows the combinational rule below.
- next_pc is combinational: redirect ? redirect_pc : (btb_hit ? btb_pred_pc : if_pc+4). Addition wraps mod 2^ADDR_W.
- Shadow regs: ID stage {v,pc,hit,pred}; EX stage {v,pc,hit,pred}.
  - Priority per stage: rst > flush (external or bp_flush) → v=0 > stall → hold > advance.
  - IF→ID always captures v=1.
- Resolution is combinational in the cycle EX v=1 and resolved=0. Let seq=pc+4.
  - br & taken & hit & pred==target: correct; no action.
  - br & taken & (!hit | pred!=target): redirect to target; enqueue insert{pc,target}.
  - br & !taken & hit: redirect to seq; enqueue invalidate{pc}.
  - br & !taken & !hit: correct.
  - !br & hit (alias): redirect to seq; enqueue invalidate{pc}.
- resolved flag:
  - Set when EX resolves while stall_idex=1.
  - Cleared when EX advances or is flushed.
  - This guarantees exactly one redirect and one enqueue per EX instruction.
- Enqueue occurs on the clk edge of the redirect cycle.
- FIFO (UQ_DEPTH entries, ptrs wrap):
  - Head drives upd_*; upd_valid = !empty.
  - Head stays stable until upd_valid & upd_ready.
  - Enqueue and dequeue in the same cycle are both honoured, including when full.
  - Enqueue when full with no dequeue: request dropped, upd_drop=1 for that cycle. Redirect is still asserted.
- Reset mid-operation clears the FIFO immediately; a pending update is lost.

Optional Feature:
- Macro BP_STATS_EN.
- Defined: adds outputs stat_br, stat_miss, stat_drop (32-bit each).
  - Count resolved branches, redirects and drops.
  - Saturate at 0xFFFFFFFF; cleared by rst.
  - stat_br counts only once per instruction, per the resolved rule.
- Undefined: ports and counters absent; other behaviour identical.

Test Plan:
- Reset, if_pc=0x100, btb_hit=0 → next_pc=0x104, upd_valid=0, redirect=0.
- Branch PC 0x200, no hit; EX taken to 0x240 → redirect=1, redirect_pc=0x240, bp_flush=1 one cycle; upd_valid next cycle with op=0, pc=0x200, target=0x240; held until upd_ready.
- Hit pred 0x240, EX not taken → redirect_pc=0x204; invalidate pc=0x200 queued; hit and correct-taken case → no redirect, no enqueue.
- Mispredict while stall_idex=1 for 3 cycles → redirect exactly one cycle; exactly one FIFO entry.
- upd_ready=0, three mispredicts → first two queued, third gives upd_drop=1; then upd_ready=1 → two updates drained in order.
- rst asserted with FIFO holding 2 entries → upd_valid=0 immediately, shadow valid cleared, no redirect.
